// File: rtl/adpll_cfg_pkg.sv
// ---------------------------------------------------------------------------
// adpll_cfg_pkg
// Shared definitions for the ADPLL configuration sequencer:
//   - command opcode encodings (cmd_op)
//   - sequencer FSM state encoding
//   - default timing parameters
//   - counter reload helper
// Optional feature macro used by the design: ADPLL_CFG_SHADOW_EN
// ---------------------------------------------------------------------------
package adpll_cfg_pkg;

    localparam int PGM_HOLD_DEF   = 2;
    localparam int CLR_CYCLES_DEF = 2;
    localparam int SETTLE_DEF     = 4;

    typedef enum logic [1:0] {
        OP_WRITE       = 2'b00,
        OP_CLEAR       = 2'b01,
        OP_READ_OUT    = 2'b10,
        OP_READ_SHADOW = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_SETTLE = 3'd5,
        ST_RESP   = 3'd6
    } state_e;

    // Counters count down to zero, so an N-cycle state is loaded with N-1.
    function automatic logic [3:0] cnt_load(input int cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/adpll_cfg_shadow.sv
// ---------------------------------------------------------------------------
// adpll_cfg_shadow
// 8 x 5-bit shadow copy of the values programmed into the ADPLL.
// Only instantiated when ADPLL_CFG_SHADOW_EN is defined.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset (zeroes all entries)
//   i_we, i_waddr,
//   i_wdata            write one entry
//   i_clr              zero every entry (takes priority over write)
//   i_raddr, o_rdata   asynchronous read port
// ---------------------------------------------------------------------------
module adpll_cfg_shadow (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_we,
    input  logic [2:0] i_waddr,
    input  logic [4:0] i_wdata,
    input  logic       i_clr,
    input  logic [2:0] i_raddr,
    output logic [4:0] o_rdata
);

    logic [4:0] r_mem [0:7];

    // Shadow storage: reset/clear zero all entries, otherwise write on request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= 5'd0;
            end
        end else if (i_clr) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= 5'd0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/adpll_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// adpll_cfg_sequencer
// Turns single-transfer commands into correctly timed ADPLL programming
// sequences (write strobe, clear pulse, readback with settle time).
// Optional feature: ADPLL_CFG_SHADOW_EN adds an 8x5 shadow of written values
// readable with READ_SHADOW; without it READ_SHADOW answers with rd_err=1.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_sel, cmd_val      command opcode, parameter index, value
//   clr, pgm, out_sel,
//   param_sel, pgm_value          ADPLL programming port (all registered)
//   dout, sign                    ADPLL readback data
//   rd_valid, rd_data, rd_err     readback response (rd_valid one-cycle pulse)
//   busy                          inverse of cmd_ready
// ---------------------------------------------------------------------------
module adpll_cfg_sequencer
    import adpll_cfg_pkg::*;
#(
    parameter int PGM_HOLD   = PGM_HOLD_DEF,
    parameter int CLR_CYCLES = CLR_CYCLES_DEF,
    parameter int SETTLE     = SETTLE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_sel,
    input  logic [4:0] cmd_val,
    output logic       clr,
    output logic       pgm,
    output logic       out_sel,
    output logic [2:0] param_sel,
    output logic [4:0] pgm_value,
    input  logic [4:0] dout,
    input  logic       sign,
    output logic       rd_valid,
    output logic [5:0] rd_data,
    output logic       rd_err,
    output logic       busy
);

    state_e     r_state;
    logic [3:0] r_cnt;
    logic       r_clr;
    logic       r_pgm;
    logic       r_out_sel;
    logic [2:0] r_param_sel;
    logic [4:0] r_pgm_value;
    logic       r_rd_valid;
    logic [5:0] r_rd_data;
    logic       r_rd_err;

    state_e     w_state;
    logic [3:0] w_cnt;
    logic       w_clr;
    logic       w_pgm;
    logic       w_out_sel;
    logic [2:0] w_param_sel;
    logic [4:0] w_pgm_value;
    logic       w_rd_valid;
    logic [5:0] w_rd_data;
    logic       w_rd_err;

`ifdef ADPLL_CFG_SHADOW_EN
    logic       r_rd_shadow;
    logic [2:0] r_rd_sel;
    logic       w_rd_shadow;
    logic [2:0] w_rd_sel;
    logic       w_sh_we;
    logic       w_sh_clr;
    logic [4:0] w_sh_rdata;

    adpll_cfg_shadow u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_sh_we),
        .i_waddr (r_param_sel),
        .i_wdata (r_pgm_value),
        .i_clr   (w_sh_clr),
        .i_raddr (r_rd_sel),
        .o_rdata (w_sh_rdata)
    );
`endif

    // Next-state and next-output decode; strobes default low, data holds.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_clr       = 1'b0;
        w_pgm       = 1'b0;
        w_out_sel   = r_out_sel;
        w_param_sel = r_param_sel;
        w_pgm_value = r_pgm_value;
        w_rd_valid  = 1'b0;
        w_rd_data   = r_rd_data;
        w_rd_err    = r_rd_err;
`ifdef ADPLL_CFG_SHADOW_EN
        w_rd_shadow = r_rd_shadow;
        w_rd_sel    = r_rd_sel;
        w_sh_we     = 1'b0;
        w_sh_clr    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op_e'(cmd_op))
                        OP_WRITE: begin
                            // Address/data settle one cycle ahead of pgm.
                            w_param_sel = cmd_sel;
                            w_pgm_value = cmd_val;
                            w_state     = ST_SETUP;
`ifdef ADPLL_CFG_SHADOW_EN
                            w_rd_shadow = 1'b0;
`endif
                        end
                        OP_CLEAR: begin
                            w_clr   = 1'b1;
                            w_cnt   = cnt_load(CLR_CYCLES);
                            w_state = ST_CLEAR;
`ifdef ADPLL_CFG_SHADOW_EN
                            w_sh_clr = 1'b1;
`endif
                        end
                        OP_READ_OUT: begin
                            w_out_sel = cmd_sel[0];
                            w_cnt     = cnt_load(SETTLE);
                            w_state   = ST_SETTLE;
                        end
                        OP_READ_SHADOW: begin
`ifdef ADPLL_CFG_SHADOW_EN
                            // One cycle through SETUP to read the shadow entry.
                            w_rd_shadow = 1'b1;
                            w_rd_sel    = cmd_sel;
                            w_state     = ST_SETUP;
`else
                            w_rd_valid = 1'b1;
                            w_rd_data  = 6'd0;
                            w_rd_err   = 1'b1;
                            w_state    = ST_RESP;
`endif
                        end
                        default: begin
                            w_state = ST_IDLE;
                        end
                    endcase
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_SETUP: begin
`ifdef ADPLL_CFG_SHADOW_EN
                if (r_rd_shadow) begin
                    w_rd_valid = 1'b1;
                    w_rd_data  = {1'b0, w_sh_rdata};
                    w_rd_err   = 1'b0;
                    w_state    = ST_RESP;
                end else begin
                    w_pgm   = 1'b1;
                    w_cnt   = cnt_load(PGM_HOLD);
                    w_state = ST_STROBE;
                end
`else
                w_pgm   = 1'b1;
                w_cnt   = cnt_load(PGM_HOLD);
                w_state = ST_STROBE;
`endif
            end
            ST_STROBE: begin
                if (r_cnt == 4'd0) begin
                    // pgm falls here; shadow records the value just programmed.
                    w_state = ST_HOLD;
`ifdef ADPLL_CFG_SHADOW_EN
                    w_sh_we = 1'b1;
`endif
                end else begin
                    w_pgm = 1'b1;
                    w_cnt = r_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                w_state = ST_IDLE;
            end
            ST_CLEAR: begin
                if (r_cnt == 4'd0) begin
                    w_state = ST_IDLE;
                end else begin
                    w_clr = 1'b1;
                    w_cnt = r_cnt - 4'd1;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_rd_valid = 1'b1;
                    w_rd_data  = {sign, dout};
                    w_rd_err   = 1'b0;
                    w_state    = ST_RESP;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_clr       <= 1'b0;
            r_pgm       <= 1'b0;
            r_out_sel   <= 1'b0;
            r_param_sel <= 3'd0;
            r_pgm_value <= 5'd0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= 6'd0;
            r_rd_err    <= 1'b0;
`ifdef ADPLL_CFG_SHADOW_EN
            r_rd_shadow <= 1'b0;
            r_rd_sel    <= 3'd0;
`endif
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_clr       <= w_clr;
            r_pgm       <= w_pgm;
            r_out_sel   <= w_out_sel;
            r_param_sel <= w_param_sel;
            r_pgm_value <= w_pgm_value;
            r_rd_valid  <= w_rd_valid;
            r_rd_data   <= w_rd_data;
            r_rd_err    <= w_rd_err;
`ifdef ADPLL_CFG_SHADOW_EN
            r_rd_shadow <= w_rd_shadow;
            r_rd_sel    <= w_rd_sel;
`endif
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign clr       = r_clr;
    assign pgm       = r_pgm;
    assign out_sel   = r_out_sel;
    assign param_sel = r_param_sel;
    assign pgm_value = r_pgm_value;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign rd_err    = r_rd_err;

endmodule

// File: tb/tb_adpll_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adpll_cfg_sequencer
// Self-checking bench for adpll_cfg_sequencer (CLR_CYCLES=3, other defaults).
// Expected behaviour per command is described as a timeline of offsets k from
// the accept edge; a small model tracks programmed values, readback data and
// the shadow contents. Honors ADPLL_CFG_SHADOW_EN for READ_SHADOW results.
// ---------------------------------------------------------------------------
module tb_adpll_cfg_sequencer;
    import adpll_cfg_pkg::*;

    localparam int H = 2;
    localparam int C = 3;
    localparam int S = 4;
`ifdef ADPLL_CFG_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_sel;
    logic [4:0] cmd_val;
    logic       clr;
    logic       pgm;
    logic       out_sel;
    logic [2:0] param_sel;
    logic [4:0] pgm_value;
    logic [4:0] dout;
    logic       sign;
    logic       rd_valid;
    logic [5:0] rd_data;
    logic       rd_err;
    logic       busy;

    adpll_cfg_sequencer #(
        .PGM_HOLD   (H),
        .CLR_CYCLES (C),
        .SETTLE     (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_sel   (cmd_sel),
        .cmd_val   (cmd_val),
        .clr       (clr),
        .pgm       (pgm),
        .out_sel   (out_sel),
        .param_sel (param_sel),
        .pgm_value (pgm_value),
        .dout      (dout),
        .sign      (sign),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_err    (rd_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [2:0] m_param_sel;
    logic [4:0] m_pgm_value;
    logic       m_out_sel;
    logic [5:0] m_rd_data;
    logic       m_rd_err;
    logic [4:0] m_shadow [8];

    typedef struct {
        logic [1:0] op;
        logic [2:0] sel;
        logic [4:0] val;
        logic [4:0] d;
        logic       s;
        bit         is_rd;
        logic [5:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t tv [11];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_param_sel = 3'd0;
        m_pgm_value = 5'd0;
        m_out_sel   = 1'b0;
        m_rd_data   = 6'd0;
        m_rd_err    = 1'b0;
        for (int i = 0; i < 8; i++) m_shadow[i] = 5'd0;
    endtask

    task automatic check_outputs(input string tag, input bit e_busy, input bit e_pgm,
                                 input bit e_clr, input bit e_rv);
        chk({tag, ".busy"},      int'(busy),      int'(e_busy));
        chk({tag, ".cmd_ready"}, int'(cmd_ready), int'(!e_busy));
        chk({tag, ".pgm"},       int'(pgm),       int'(e_pgm));
        chk({tag, ".clr"},       int'(clr),       int'(e_clr));
        chk({tag, ".rd_valid"},  int'(rd_valid),  int'(e_rv));
        chk({tag, ".param_sel"}, int'(param_sel), int'(m_param_sel));
        chk({tag, ".pgm_value"}, int'(pgm_value), int'(m_pgm_value));
        chk({tag, ".out_sel"},   int'(out_sel),   int'(m_out_sel));
        chk({tag, ".rd_data"},   int'(rd_data),   int'(m_rd_data));
        chk({tag, ".rd_err"},    int'(rd_err),    int'(m_rd_err));
    endtask

    function automatic int cmd_len(input logic [1:0] op);
        case (op)
            OP_WRITE:    return H + 2;
            OP_CLEAR:    return C;
            OP_READ_OUT: return S + 1;
            default:     return SH ? 2 : 1;
        endcase
    endfunction

    function automatic int resp_k(input logic [1:0] op);
        if (op == OP_READ_OUT) return S;
        if (op == OP_READ_SHADOW) return SH ? 1 : 0;
        return -1;
    endfunction

    // Called at the sample point just after the accept edge (k=0).
    task automatic track(input logic [1:0] op, input logic [2:0] sel, input logic [4:0] val,
                         input logic [4:0] d, input logic s, input bit keep_valid);
        int len = cmd_len(op);
        int rk  = resp_k(op);
        if (op == OP_WRITE) begin
            m_param_sel = sel;
            m_pgm_value = val;
        end
        if (op == OP_READ_OUT) m_out_sel = sel[0];
        for (int k = 0; k <= len; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k == len && !keep_valid) cmd_valid = 1'b0;
            if (k == rk) begin
                if (op == OP_READ_OUT) begin
                    m_rd_data = {s, d};
                    m_rd_err  = 1'b0;
                end else if (SH) begin
                    m_rd_data = {1'b0, m_shadow[sel]};
                    m_rd_err  = 1'b0;
                end else begin
                    m_rd_data = 6'd0;
                    m_rd_err  = 1'b1;
                end
            end
            check_outputs($sformatf("op%0d.k%0d", op, k), k < len,
                          (op == OP_WRITE) && k >= 1 && k <= H,
                          (op == OP_CLEAR) && k < C,
                          k == rk);
        end
        if (op == OP_WRITE) m_shadow[sel] = val;
        if (op == OP_CLEAR) for (int i = 0; i < 8; i++) m_shadow[i] = 5'd0;
    endtask

    // Presents a command while idle and returns at the sample after acceptance.
    task automatic issue(input logic [1:0] op, input logic [2:0] sel, input logic [4:0] val);
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_val   = val;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] sel, input logic [4:0] val,
                           input logic [4:0] d, input logic s, input bit noise);
        dout = d;
        sign = s;
        issue(op, sel, val);
        if (noise) begin
            // Junk presented while busy must be ignored.
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_sel   = 3'($urandom_range(0, 7));
            cmd_val   = 5'($urandom_range(0, 31));
            cmd_valid = 1'b1;
        end else begin
            cmd_valid = 1'b0;
        end
        track(op, sel, val, d, s, 1'b0);
    endtask

    task automatic reset_mid(input logic [1:0] op);
        issue(op, 3'd4, 5'h0B);
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        if (op == OP_WRITE) chk("pre_rst.pgm", int'(pgm), 1);
        else                chk("pre_rst.clr", int'(clr), 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("in_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("post_rst2", 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] bsel;

        tv[0]  = '{OP_WRITE,       3'd3, 5'h15, 5'h00, 1'b0, 1'b0, 6'h00, 1'b0};
        tv[1]  = '{OP_CLEAR,       3'd0, 5'h00, 5'h00, 1'b0, 1'b0, 6'h00, 1'b0};
        tv[2]  = '{OP_READ_OUT,    3'd1, 5'h00, 5'h0A, 1'b1, 1'b1, 6'h2A, 1'b0};
        tv[3]  = '{OP_WRITE,       3'd5, 5'h1F, 5'h00, 1'b0, 1'b0, 6'h00, 1'b0};
        tv[4]  = '{OP_READ_SHADOW, 3'd5, 5'h00, 5'h00, 1'b0, 1'b1, SH ? 6'h1F : 6'h00, !SH};
        tv[5]  = '{OP_READ_OUT,    3'd0, 5'h00, 5'h13, 1'b0, 1'b1, 6'h13, 1'b0};
        tv[6]  = '{OP_WRITE,       3'd2, 5'h0C, 5'h00, 1'b0, 1'b0, 6'h00, 1'b0};
        tv[7]  = '{OP_READ_SHADOW, 3'd2, 5'h00, 5'h00, 1'b0, 1'b1, SH ? 6'h0C : 6'h00, !SH};
        tv[8]  = '{OP_CLEAR,       3'd7, 5'h00, 5'h00, 1'b0, 1'b0, 6'h00, 1'b0};
        tv[9]  = '{OP_READ_SHADOW, 3'd5, 5'h00, 5'h00, 1'b0, 1'b1, 6'h00, !SH};
        tv[10] = '{OP_READ_OUT,    3'd1, 5'h00, 5'h1F, 1'b1, 1'b1, 6'h3F, 1'b0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_sel   = 3'd0;
        cmd_val   = 5'd0;
        dout      = 5'd0;
        sign      = 1'b0;
        model_reset();
        #12;
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // directed vector table
        for (int i = 0; i < 11; i++) begin
            run_cmd(tv[i].op, tv[i].sel, tv[i].val, tv[i].d, tv[i].s, 1'b0);
            if (tv[i].is_rd) begin
                chk($sformatf("tv%0d.rd_data", i), int'(rd_data), int'(tv[i].exp_data));
                chk($sformatf("tv%0d.rd_err", i),  int'(rd_err),  int'(tv[i].exp_err));
            end
        end

        // cmd_valid held high: WRITE then READ_OUT, second waits for cmd_ready
        dout = 5'h11;
        sign = 1'b0;
        bsel = {2'b00, ~m_out_sel};
        issue(OP_WRITE, 3'd6, 5'h07);
        cmd_op  = OP_READ_OUT;
        cmd_sel = bsel;
        cmd_val = 5'h1A;
        track(OP_WRITE, 3'd6, 5'h07, dout, sign, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        track(OP_READ_OUT, bsel, 5'h1A, 5'h11, 1'b0, 1'b0);

        // reset during STROBE and during CLEAR, then normal operation
        reset_mid(OP_WRITE);
        run_cmd(OP_WRITE, 3'd1, 5'h09, 5'h00, 1'b0, 1'b0);
        run_cmd(OP_READ_SHADOW, 3'd5, 5'h00, 5'h00, 1'b0, 1'b0);
        reset_mid(OP_CLEAR);
        run_cmd(OP_READ_SHADOW, 3'd1, 5'h00, 5'h00, 1'b0, 1'b0);

        // randomized commands
        for (int i = 0; i < 80; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
